eq_band_scheduler: RTL and testbench

Sequences one shared biquad arithmetic unit across NBANDS equalizer bands for each incoming audio sample. For each enabled band it issues a start to the arithmetic controller, waits for its result-ready pulse, and accumulates the band output. When all enabled bands are done it emits one summed output sample. It sits between the audio sample interface and the arithmetic-unit controller/datapath; the datapath holds per-band coefficients and state selected by `arith_band`.

---
 rtl/eq_band_scheduler.sv | 163 ++++++++++++++++
 tb/tb_eq_band_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_scheduler.sv
// eq_band_scheduler: time-shares one biquad arithmetic unit across NBANDS
// equalizer bands for every incoming audio sample, sums the enabled band
// outputs and emits one output sample per input strobe.
// Optional feature: define EQ_SAT_EN to saturate the summed output to W bits
// instead of wrapping it.
module eq_band_scheduler #(
    parameter int NBANDS  = 3,
    parameter int W       = 12,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_strobe,
    input  logic [W-1:0]      sample_in,
    input  logic [NBANDS-1:0] band_en,
    output logic              arith_start,
    output logic [1:0]        arith_band,
    output logic [W-1:0]      arith_x,
    input  logic              arith_done,
    input  logic [W-1:0]      arith_y,
    output logic [W-1:0]      sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

`ifdef EQ_SAT_EN
    localparam logic signed [W+1:0] SAT_MAX = $signed({3'b000, {(W-1){1'b1}}});
    localparam logic signed [W+1:0] SAT_MIN = $signed({3'b111, {(W-1){1'b0}}});
`endif

    logic [1:0]           state;
    logic signed [W+1:0]  acc;
    logic signed [W-1:0]  x_reg;
    logic [NBANDS-1:0]    mask_reg;
    logic [CNT_W-1:0]     wait_cnt;
    logic [1:0]           band;
    logic signed [W-1:0]  out_reg;

    logic [1:0]           first_band;
    logic [1:0]           nxt_band;
    logic                 nxt_found;
    logic signed [W+1:0]  acc_upd;
    logic signed [W+1:0]  in_ext;
    logic                 band_end;

    // Sign-extend a W-bit sample into the accumulator width.
    function automatic logic signed [W+1:0] sext(input logic [W-1:0] v);
        return $signed({{2{v[W-1]}}, v});
    endfunction

    // Reduce the W+2 bit accumulator to the W-bit output sample.
    function automatic logic signed [W-1:0] out_conv(input logic signed [W+1:0] a);
`ifdef EQ_SAT_EN
        if (a > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (a < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return a[W-1:0];
`else
        return W'(a);
`endif
    endfunction

    // Lowest enabled band of the incoming mask and next higher band of the captured mask.
    always_comb begin
        first_band = 2'd0;
        nxt_band   = 2'd0;
        nxt_found  = 1'b0;
        for (int i = NBANDS - 1; i >= 0; i--) begin
            if (band_en[i])
                first_band = i[1:0];
            if (mask_reg[i] && (i > int'(band))) begin
                nxt_band  = i[1:0];
                nxt_found = 1'b1;
            end
        end
    end

    // A band finishes on its done pulse (which wins over a coincident timeout)
    // or when the wait counter reaches TIMEOUT; a timed-out band adds nothing.
    always_comb begin
        in_ext   = sext(sample_in);
        acc_upd  = arith_done ? (acc + sext(arith_y)) : acc;
        band_end = arith_done || (wait_cnt == TMO);
    end

    // Scheduler state machine, accumulator and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            acc         <= '0;
            x_reg       <= '0;
            mask_reg    <= '0;
            wait_cnt    <= '0;
            band        <= 2'd0;
            out_reg     <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (sample_strobe && (state != S_IDLE))
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (sample_strobe) begin
                        x_reg    <= $signed(sample_in);
                        mask_reg <= band_en;
                        if (|band_en) begin
                            acc   <= '0;
                            band  <= first_band;
                            state <= S_ISSUE;
                        end else begin
                            acc     <= in_ext;
                            out_reg <= out_conv(in_ext);
                            state   <= S_OUT;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (band_end) begin
                        if (!arith_done)
                            timeout_err <= 1'b1;
                        acc <= acc_upd;
                        if (nxt_found) begin
                            band  <= nxt_band;
                            state <= S_ISSUE;
                        end else begin
                            out_reg <= out_conv(acc_upd);
                            state   <= S_OUT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign arith_start  = (state == S_ISSUE);
    assign arith_band   = ((state == S_ISSUE) || (state == S_WAIT)) ? band : 2'd0;
    assign arith_x      = ((state == S_ISSUE) || (state == S_WAIT)) ? x_reg : '0;
    assign sample_out   = out_reg;
    assign sample_valid = (state == S_OUT);
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Self-checking bench for eq_band_scheduler. A behavioural arithmetic-unit
// responder answers each start after a per-band latency; expected sums,
// start order and latencies come from a plain arithmetic model of the bands.
module tb_eq_band_scheduler;
    localparam int NBANDS  = 3;
    localparam int W       = 12;
    localparam int TIMEOUT = 63;

    logic              clk = 1'b0;
    logic              reset;
    logic              sample_strobe;
    logic [W-1:0]      sample_in;
    logic [NBANDS-1:0] band_en;
    logic              arith_start;
    logic [1:0]        arith_band;
    logic [W-1:0]      arith_x;
    logic              arith_done;
    logic [W-1:0]      arith_y;
    logic [W-1:0]      sample_out;
    logic              sample_valid;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    int resp_lat   [4] = '{default: 1};
    int resp_yv    [4] = '{default: 0};
    bit resp_never [4] = '{default: 1'b0};
    int late_req_n = 0;
    int late_ack_n = 0;
    int late_y     = 0;
    int hold_bad   = 0;
    int valid_total = 0;
    logic [1:0]   start_band_q [$];
    logic [W-1:0] start_x_q    [$];

    eq_band_scheduler #(.NBANDS(NBANDS), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .sample_strobe(sample_strobe), .sample_in(sample_in),
        .band_en(band_en), .arith_start(arith_start), .arith_band(arith_band),
        .arith_x(arith_x), .arith_done(arith_done), .arith_y(arith_y),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Behavioural arithmetic unit: done arrives resp_lat cycles after start.
    initial begin
        int           cnt;
        logic [W-1:0] pend_y;
        logic [1:0]   cur_band;
        logic [W-1:0] cur_x;
        cnt = 0; pend_y = '0; cur_band = 2'd0; cur_x = '0;
        arith_done = 1'b0;
        arith_y    = '0;
        forever begin
            @(negedge clk);
            arith_done = 1'b0;
            arith_y    = W'($urandom);
            if (late_ack_n != late_req_n) begin
                late_ack_n = late_req_n;
                arith_done = 1'b1;
                arith_y    = W'(late_y);
            end
            if (cnt > 0) begin
                if (arith_band !== cur_band || arith_x !== cur_x) hold_bad++;
                cnt--;
                if (cnt == 0) begin
                    arith_done = 1'b1;
                    arith_y    = pend_y;
                end
            end
            if (arith_start === 1'b1) begin
                start_band_q.push_back(arith_band);
                start_x_q.push_back(arith_x);
                cur_band = arith_band;
                cur_x    = arith_x;
                if (!resp_never[arith_band]) begin
                    cnt    = resp_lat[arith_band];
                    pend_y = W'(resp_yv[arith_band]);
                end
            end
        end
    end

    // Count every sample_valid pulse.
    initial forever begin
        @(negedge clk);
        if (sample_valid === 1'b1) valid_total++;
    end

    function automatic int conv(input int s);
        int r;
        r = s;
`ifdef EQ_SAT_EN
        if (s > (1 << (W-1)) - 1) r = (1 << (W-1)) - 1;
        if (s < -(1 << (W-1)))    r = -(1 << (W-1));
`else
        r = s % (1 << W);
        if (r < 0) r += (1 << W);
        if (r >= (1 << (W-1))) r -= (1 << W);
`endif
        return r;
    endfunction

    function automatic int model_out(input logic [NBANDS-1:0] m, input int x);
        int s;
        if (m == '0) return conv(x);
        s = 0;
        for (int b = 0; b < NBANDS; b++)
            if (m[b] && !resp_never[b]) s += resp_yv[b];
        return conv(s);
    endfunction

    // Cycles from the strobe edge to the negedge that sees sample_valid.
    function automatic int model_lat(input logic [NBANDS-1:0] m, input bit upper);
        int s;
        if (m == '0) return 1;
        s = 1;
        for (int b = 0; b < NBANDS; b++)
            if (m[b]) s += 1 + (resp_never[b] ? (upper ? TIMEOUT + 1 : TIMEOUT) : resp_lat[b]);
        return s;
    endfunction

    task automatic run_sample(input int x, input logic [NBANDS-1:0] m, input int ovr_at,
                              output logic [W-1:0] got, output int lat, output bit seen);
        seen = 1'b0; lat = 0; got = '0;
        @(negedge clk);
        sample_in = W'(x); band_en = m; sample_strobe = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            sample_strobe = (k == ovr_at);
            sample_in     = W'($urandom);
            band_en       = NBANDS'($urandom);
            if (sample_valid === 1'b1) begin
                seen = 1'b1; lat = k; got = sample_out;
                break;
            end
        end
        sample_strobe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({arith_start, arith_band, arith_x, sample_out, sample_valid, busy, overrun, timeout_err} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got start=%b band=%0d x=%0d out=%0d v=%b busy=%b ovr=%b to=%b, want all 0",
                arith_start, arith_band, arith_x, sample_out, sample_valid, busy, overrun, timeout_err);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, sample_valid, arith_start, sample_out} !== '0) begin
            n_fail++; $display("FAIL idle_after_reset: busy=%b v=%b start=%b out=%0d, want 0", busy, sample_valid, arith_start, sample_out);
        end
    endtask

    task automatic test_all_bands();
        logic [W-1:0] got; int lat; bit seen; int q0; int v0; int j;
        resp_lat = '{8, 8, 8, 8}; resp_yv = '{100, 200, 300, 0}; resp_never = '{0, 0, 0, 0};
        q0 = start_band_q.size(); #1 v0 = valid_total;
        run_sample(100, 3'b111, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(model_out(3'b111, 100))) begin
            n_fail++; $display("FAIL all_bands_out: got %0d (seen=%b), want %0d", $signed(got), seen, model_out(3'b111, 100));
        end
        n_cmp++;
        if (lat != model_lat(3'b111, 1'b0)) begin
            n_fail++; $display("FAIL all_bands_latency: got %0d, want %0d", lat, model_lat(3'b111, 1'b0));
        end
        j = q0;
        for (int b = 0; b < NBANDS; b++) begin
            n_cmp++;
            if (j >= start_band_q.size() || start_band_q[j] !== 2'(b) || start_x_q[j] !== W'(100)) begin
                n_fail++; $display("FAIL all_bands_start%0d: queue size %0d, want band %0d x 100", b, start_band_q.size(), b);
            end
            j++;
        end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (valid_total - v0 != 1 || hold_bad != 0 || sample_out !== W'(600)) begin
            n_fail++; $display("FAIL all_bands_pulse_hold: valids %0d hold_bad %0d out %0d, want 1 0 600", valid_total - v0, hold_bad, sample_out);
        end
    endtask

    task automatic test_sparse();
        logic [W-1:0] got; int lat; bit seen; int q0;
        resp_lat = '{4, 4, 4, 4}; resp_yv = '{50, 999, -20, 0};
        q0 = start_band_q.size();
        run_sample(-300, 3'b101, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(30)) begin
            n_fail++; $display("FAIL sparse_out: got %0d, want 30", $signed(got));
        end
        n_cmp++;
        if (start_band_q.size() - q0 != 2 || start_band_q[q0] !== 2'd0 || start_band_q[q0+1] !== 2'd2) begin
            n_fail++; $display("FAIL sparse_starts: %0d starts, want bands 0 and 2", start_band_q.size() - q0);
        end
        n_cmp++;
        if (lat != model_lat(3'b101, 1'b0)) begin
            n_fail++; $display("FAIL sparse_latency: got %0d, want %0d", lat, model_lat(3'b101, 1'b0));
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] got; int lat; bit seen;
        resp_lat = '{2, 3, 1, 1}; resp_yv = '{1500, 1500, 0, 0};
        run_sample(5, 3'b111, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(model_out(3'b111, 5))) begin
            n_fail++; $display("FAIL overflow_out: got %0d, want %0d", $signed(got), model_out(3'b111, 5));
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] got; int lat; bit seen; int q0; int v0;
        resp_lat = '{5, 5, 5, 5}; resp_yv = '{-400, 123, 77, 0};
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL overrun_initial: got %b, want 0", overrun);
        end
        q0 = start_band_q.size(); #1 v0 = valid_total;
        run_sample(42, 3'b111, 4, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(-200) || lat != model_lat(3'b111, 1'b0)) begin
            n_fail++; $display("FAIL overrun_first_sample: got %0d lat %0d, want -200 lat %0d", $signed(got), lat, model_lat(3'b111, 1'b0));
        end
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b0 || valid_total - v0 != 1 || start_band_q.size() - q0 != 3) begin
            n_fail++; $display("FAIL overrun_sticky: ovr=%b busy=%b valids=%0d starts=%0d, want 1 0 1 3",
                overrun, busy, valid_total - v0, start_band_q.size() - q0);
        end
        n_cmp++;
        if (sample_out !== got) begin
            n_fail++; $display("FAIL overrun_out_held: got %0d, want %0d", $signed(sample_out), $signed(got));
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] got; int lat; bit seen;
        resp_lat = '{2, 2, 2, 2}; resp_yv = '{10, 700, 5, 0}; resp_never = '{0, 1, 0, 0};
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_initial: got %b, want 0", timeout_err);
        end
        run_sample(9, 3'b111, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(15)) begin
            n_fail++; $display("FAIL timeout_out: got %0d, want 15", $signed(got));
        end
        n_cmp++;
        if (timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_flag: got %b, want 1", timeout_err);
        end
        n_cmp++;
        if (lat < model_lat(3'b111, 1'b0) || lat > model_lat(3'b111, 1'b1)) begin
            n_fail++; $display("FAIL timeout_latency: got %0d, want %0d..%0d", lat, model_lat(3'b111, 1'b0), model_lat(3'b111, 1'b1));
        end
        resp_never = '{0, 0, 0, 0};
    endtask

    task automatic test_bypass();
        logic [W-1:0] got; int lat; bit seen; int q0;
        q0 = start_band_q.size();
        run_sample(-7, 3'b000, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(-7) || lat != 1) begin
            n_fail++; $display("FAIL bypass: got %0d lat %0d, want -7 lat 1", $signed(got), lat);
        end
        n_cmp++;
        if (start_band_q.size() != q0) begin
            n_fail++; $display("FAIL bypass_no_start: %0d starts, want 0", start_band_q.size() - q0);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got; int lat; bit seen;
        resp_lat = '{1, 3, 2, 1}; resp_yv = '{-1000, -1000, -500, 0};
        run_sample(0, 3'b111, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(model_out(3'b111, 0)) || lat != model_lat(3'b111, 1'b0)) begin
            n_fail++; $display("FAIL b2b_first: got %0d lat %0d, want %0d lat %0d", $signed(got), lat, model_out(3'b111, 0), model_lat(3'b111, 1'b0));
        end
        run_sample(-2048, 3'b000, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(-2048) || lat != 1) begin
            n_fail++; $display("FAIL b2b_second: got %0d lat %0d, want -2048 lat 1", $signed(got), lat);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [W-1:0] got; int lat; bit seen; int v0; int bad;
        resp_lat = '{3, 3, 3, 3}; resp_yv = '{11, 22, 33, 0}; resp_never = '{0, 1, 0, 0};
        @(negedge clk);
        sample_in = W'(55); band_en = 3'b111; sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || arith_band !== 2'd1) begin
            n_fail++; $display("FAIL rst_mid_setup: busy=%b band=%0d, want 1 1", busy, arith_band);
        end
        reset = 1'b1;
        #1 v0 = valid_total;
        n_cmp++;
        if ({arith_start, arith_band, arith_x, sample_out, sample_valid, busy, overrun, timeout_err} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: start=%b band=%0d x=%0d out=%0d v=%b busy=%b ovr=%b to=%b, want all 0",
                arith_start, arith_band, arith_x, sample_out, sample_valid, busy, overrun, timeout_err);
        end
        @(negedge clk);
        reset = 1'b0;
        resp_never = '{0, 0, 0, 0};
        late_y = 333;
        late_req_n++;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || arith_start !== 1'b0 || sample_out !== '0) bad++;
        end
        #1;
        n_cmp++;
        if (bad != 0 || valid_total != v0) begin
            n_fail++; $display("FAIL rst_mid_late_done: %0d bad cycles, %0d valids, want 0 0", bad, valid_total - v0);
        end
        run_sample(55, 3'b011, 0, got, lat, seen);
        n_cmp++;
        if (!seen || got !== W'(33) || lat != model_lat(3'b011, 1'b0)) begin
            n_fail++; $display("FAIL rst_mid_recover: got %0d lat %0d, want 33 lat %0d", $signed(got), lat, model_lat(3'b011, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] got; int lat; bit seen; int q0; int x; int j;
        logic [NBANDS-1:0] m;
        for (int it = 0; it < 25; it++) begin
            m = NBANDS'($urandom_range(0, (1 << NBANDS) - 1));
            x = int'($urandom_range(0, 4095)) - 2048;
            for (int b = 0; b < 4; b++) begin
                resp_lat[b] = int'($urandom_range(1, 6));
                resp_yv[b]  = int'($urandom_range(0, 4095)) - 2048;
            end
            q0 = start_band_q.size();
            run_sample(x, m, 0, got, lat, seen);
            n_cmp++;
            if (!seen || got !== W'(model_out(m, x)) || lat != model_lat(m, 1'b0)) begin
                n_fail++; $display("FAIL random%0d mask=%b: got %0d lat %0d, want %0d lat %0d",
                    it, m, $signed(got), lat, model_out(m, x), model_lat(m, 1'b0));
            end
            j = q0;
            for (int b = 0; b < NBANDS; b++) begin
                if (m[b]) begin
                    n_cmp++;
                    if (j >= start_band_q.size() || start_band_q[j] !== 2'(b) || start_x_q[j] !== W'(x)) begin
                        n_fail++; $display("FAIL random%0d_start: index %0d, want band %0d x %0d", it, j - q0, b, x);
                    end
                    j++;
                end
            end
            n_cmp++;
            if (start_band_q.size() != j) begin
                n_fail++; $display("FAIL random%0d_start_count: got %0d, want %0d", it, start_band_q.size() - q0, j - q0);
            end
        end
        n_cmp++;
        if (hold_bad != 0 || overrun !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++; $display("FAIL random_flags: hold_bad=%0d ovr=%b to=%b, want 0 0 0", hold_bad, overrun, timeout_err);
        end
    endtask

    initial begin
        reset = 1'b1;
        sample_strobe = 1'b0;
        sample_in = '0;
        band_en = '0;
        test_reset();
        test_all_bands();
        test_sparse();
        test_overflow();
        test_overrun();
        test_timeout();
        test_bypass();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
